// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared constants and helpers for the scanned RGB LED driver.
// Optional feature macro used by the top: LED_SCAN_BLANK_EN.
package led_scan_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;

    // Upper bounds for the generic channel extractor below.
    localparam int MAX_VEC_W    = 4096;
    localparam int MAX_PWM_BITS = 16;

    // Extract channel ch of LED led from a packed {LED n-1 .. LED 0} vector,
    // where each LED is {red, green, blue} of pwm_bits each.
    function automatic logic [MAX_PWM_BITS-1:0] get_chan(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   led,
        input int                   ch,
        input int                   pwm_bits
    );
        logic [MAX_PWM_BITS-1:0] mask;
        mask = (MAX_PWM_BITS'(1) << pwm_bits) - MAX_PWM_BITS'(1);
        return MAX_PWM_BITS'(vec >> ((led * NUM_CH + ch) * pwm_bits)) & mask;
    endfunction

endpackage

// File: rtl/led_scan_if.sv
// led_scan_if: shadow-frame write port (one LED's intensities per cycle).
interface led_scan_if #(
    parameter int NUM_LEDS = 7,
    parameter int PWM_BITS = 4
);
    import led_scan_pkg::*;

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                       wr_en;
    logic [IDX_W-1:0]           wr_idx;
    logic [NUM_CH*PWM_BITS-1:0] wr_data;

    modport master (output wr_en, output wr_idx, output wr_data);
    modport slave  (input  wr_en, input  wr_idx, input  wr_data);

endinterface

// File: rtl/led_scan_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, polarity fix, stability counter,
// debounced level and a one-cycle pulse on an accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic state_o,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_s;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pressed = 1 after optional inversion of the synchronised pin.
    assign level_s = sync2_q ^ ACTIVE_LOW;

    // Synchroniser flops reset to the idle pin level so reset reads "released".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; accept the level on the last one.
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (level_s != state_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                state_d = level_s;
                press_d = level_s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign press_o = press_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed RGB LED scan with per-channel PWM,
// double-buffered frame, and debounced buttons.
// Optional: define LED_SCAN_BLANK_EN to blank all LEDs during pwm step 0.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int NUM_LEDS        = 7,
    parameter int NUM_BUTTONS     = 2,
    parameter int PWM_BITS        = 4,
    parameter int SLOT_DIV        = 64,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    led_scan_if.slave              wr_bus,
    output logic                   frame_start,
    output logic [NUM_CH-1:0]      user_leds_color,
    output logic [NUM_LEDS-1:0]    user_leds_en,
    input  logic [NUM_BUTTONS-1:0] user_buttons,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_press
);
    localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PRE_W   = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam int LED_W   = NUM_CH * PWM_BITS;
    localparam int FRAME_W = NUM_LEDS * LED_W;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [IDX_W-1:0]    slot_q, slot_d;
    logic [FRAME_W-1:0]  shadow_q, active_q;
    logic                frame_start_q, frame_start_d;
    logic [NUM_CH-1:0]   color_q, color_d;
    logic [NUM_LEDS-1:0] en_q, en_d;
    logic                step_s, pwm_wrap_s, frame_wrap_s, wr_hit_s, blank_s;
    logic [MAX_VEC_W-1:0] active_ext_s;

    assign step_s       = (presc_q == PRE_W'(SLOT_DIV - 1));
    assign pwm_wrap_s   = step_s && (pwm_q == {PWM_BITS{1'b1}});
    assign frame_wrap_s = pwm_wrap_s && (slot_q == IDX_W'(NUM_LEDS - 1));
    assign wr_hit_s     = wr_bus.wr_en && (int'(wr_bus.wr_idx) < NUM_LEDS);
    assign active_ext_s = MAX_VEC_W'(active_q);

`ifdef LED_SCAN_BLANK_EN
    assign blank_s = (pwm_q == '0);
`else
    assign blank_s = 1'b0;
`endif

    // Prescaler -> pwm step -> slot counter chain.
    always_comb begin
        presc_d = step_s ? '0 : presc_q + PRE_W'(1);
        pwm_d   = step_s ? pwm_q + PWM_BITS'(1) : pwm_q;
        if (frame_wrap_s) begin
            slot_d = '0;
        end else if (pwm_wrap_s) begin
            slot_d = slot_q + IDX_W'(1);
        end else begin
            slot_d = slot_q;
        end
    end

    // Output drive for the current counter position; registered below so
    // enable and color always change on the same edge.
    always_comb begin
        frame_start_d = (presc_q == '0) && (pwm_q == '0) && (slot_q == '0);
        en_d          = '0;
        color_d       = {NUM_CH{1'b1}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            en_d[i] = (int'(slot_q) == i);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            color_d[ch] = !(pwm_q < PWM_BITS'(get_chan(active_ext_s, int'(slot_q), ch, PWM_BITS)));
        end
        if (blank_s) begin
            en_d    = '0;
            color_d = {NUM_CH{1'b1}};
        end else begin
            en_d    = en_d;
            color_d = color_d;
        end
    end

    // Scan counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q       <= '0;
            pwm_q         <= '0;
            slot_q        <= '0;
            frame_start_q <= 1'b0;
            en_q          <= '0;
            color_q       <= {NUM_CH{1'b1}};
        end else begin
            presc_q       <= presc_d;
            pwm_q         <= pwm_d;
            slot_q        <= slot_d;
            frame_start_q <= frame_start_d;
            en_q          <= en_d;
            color_q       <= color_d;
        end
    end

    // Shadow frame takes host writes; out-of-range indices are dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_q <= '0;
        end else if (wr_hit_s) begin
            shadow_q[int'(wr_bus.wr_idx)*LED_W +: LED_W] <= wr_bus.wr_data;
        end else begin
            shadow_q <= shadow_q;
        end
    end

    // Whole frame is latched into the active buffer as the slot counter wraps;
    // a write on the same edge only reaches shadow.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            active_q <= '0;
        end else if (frame_wrap_s) begin
            active_q <= shadow_q;
        end else begin
            active_q <= active_q;
        end
    end

    assign frame_start     = frame_start_q;
    assign user_leds_en    = en_q;
    assign user_leds_color = color_q;

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk_i     (sys_clk),
            .rst_ni    (sys_rst_n),
            .btn_raw_i (user_buttons[b]),
            .state_o   (btn_state[b]),
            .press_o   (btn_press[b])
        );
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized self-checking bench for led_scan_ctrl with a
// frame-arithmetic reference model (small SLOT_DIV / DEBOUNCE_CYCLES).
module tb_led_scan_ctrl;
    localparam int NL       = 7;
    localparam int NB       = 2;
    localparam int PB       = 4;
    localparam int SD       = 4;
    localparam int DB       = 200;
    localparam int STEPS    = 16;
    localparam int SLOT_LEN = STEPS * SD;
    localparam int FRAME    = NL * SLOT_LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start;
    logic [2:0]    color;
    logic [NL-1:0] en;
    logic [NB-1:0] raw = 2'b11;
    logic [NB-1:0] bst, bpr;

    led_scan_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) wr_bus();

    led_scan_ctrl #(
        .NUM_LEDS(NL), .NUM_BUTTONS(NB), .PWM_BITS(PB), .SLOT_DIV(SD),
        .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_bus(wr_bus),
        .frame_start(frame_start), .user_leds_color(color), .user_leds_en(en),
        .user_buttons(raw), .btn_state(bst), .btn_press(bpr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            n;
    logic [11:0]   shadow_m [NL];
    logic [11:0]   active_m [NL];
    logic          e_fs;
    logic [2:0]    e_col;
    logic [NL-1:0] e_en;
    logic [NB-1:0] b_state_m, b_press_m, d1_m, d2_m;
    int            run_m [NB];

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NL; i++) begin
            shadow_m[i] = 12'h000;
            active_m[i] = 12'h000;
        end
        e_fs = 1'b0; e_col = 3'b111; e_en = '0;
        b_state_m = '0; b_press_m = '0; d1_m = '0; d2_m = '0;
        for (int b = 0; b < NB; b++) run_m[b] = 0;
    endtask

    // One clock edge: expected outputs show the scan position held before the
    // edge; then frame copy, host write and button model advance.
    task automatic tick();
        int c, slot, step;
        @(posedge clk);
        c    = n % FRAME;
        slot = c / SLOT_LEN;
        step = (c / SD) % STEPS;
        e_fs = (c == 0);
        e_en = '0;
        e_en[slot] = 1'b1;
        for (int ch = 0; ch < 3; ch++)
            e_col[ch] = (step < int'(active_m[slot][ch*PB +: PB])) ? 1'b0 : 1'b1;
`ifdef LED_SCAN_BLANK_EN
        if (step == 0) begin
            e_en  = '0;
            e_col = 3'b111;
        end
`endif
        if (c == FRAME - 1)
            for (int i = 0; i < NL; i++) active_m[i] = shadow_m[i];
        if (wr_bus.wr_en && int'(wr_bus.wr_idx) < NL)
            shadow_m[wr_bus.wr_idx] = wr_bus.wr_data;
        for (int b = 0; b < NB; b++) begin
            b_press_m[b] = 1'b0;
            if (d2_m[b] != b_state_m[b]) begin
                run_m[b]++;
                if (run_m[b] == DB) begin
                    b_state_m[b] = d2_m[b];
                    b_press_m[b] = d2_m[b];
                    run_m[b] = 0;
                end
            end else begin
                run_m[b] = 0;
            end
        end
        d2_m = d1_m;
        d1_m = ~raw;
        n++;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({frame_start, en, color} !== {1'b0, 7'b0, 3'b111}) begin
            n_fail++;
            $display("FAIL reset_leds got fs/en/col=%b/%b/%b exp 0/0000000/111", frame_start, en, color);
        end
        n_checks++;
        if ({bst, bpr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_btn got state/press=%b/%b exp 00/00", bst, bpr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int fs_cnt = 0, last_fs = -1;
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            tick();
            n_checks++;
            if ({frame_start, en, color} !== {e_fs, e_en, e_col}) begin
                n_fail++;
                $display("FAIL scan n=%0d got fs/en/col=%b/%b/%b exp %b/%b/%b", n, frame_start, en, color, e_fs, e_en, e_col);
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (n - last_fs !== FRAME) begin
                        n_fail++;
                        $display("FAIL frame_period got %0d exp %0d", n - last_fs, FRAME);
                    end
                end
                last_fs = n;
                fs_cnt++;
            end
        end
        n_checks++;
        if (fs_cnt !== 3) begin
            n_fail++;
            $display("FAIL frame_count got %0d exp 3", fs_cnt);
        end
    endtask

    task automatic test_write_mid_frame();
        int guard = 0, fs_seen = 0, old_red = 0, red = 0, grn = 0, blu = 0, on3 = 0;
        int exp_red, exp_grn, exp_on;
`ifdef LED_SCAN_BLANK_EN
        exp_red = 14 * SD; exp_grn = 7 * SD; exp_on = 15 * SD;
`else
        exp_red = 15 * SD; exp_grn = 8 * SD; exp_on = 16 * SD;
`endif
        while ((n % FRAME) != 100 && guard < FRAME + 2) begin
            tick();
            guard++;
        end
        wr_bus.wr_en = 1'b1; wr_bus.wr_idx = 3'd3; wr_bus.wr_data = 12'hF80;
        tick();
        wr_bus.wr_en = 1'b0;
        for (int k = 0; k < 3 * FRAME && fs_seen < 2; k++) begin
            tick();
            n_checks++;
            if ({frame_start, en, color} !== {e_fs, e_en, e_col}) begin
                n_fail++;
                $display("FAIL write_mid n=%0d got fs/en/col=%b/%b/%b exp %b/%b/%b", n, frame_start, en, color, e_fs, e_en, e_col);
            end
            if (frame_start === 1'b1) fs_seen++;
            if (en[3] === 1'b1 && fs_seen == 0 && color[2] === 1'b0) old_red++;
            if (en[3] === 1'b1 && fs_seen == 1) begin
                on3++;
                if (color[2] === 1'b0) red++;
                if (color[1] === 1'b0) grn++;
                if (color[0] === 1'b0) blu++;
            end
        end
        n_checks++;
        if (old_red !== 0) begin n_fail++; $display("FAIL write_early got red cycles %0d exp 0", old_red); end
        n_checks++;
        if (red !== exp_red) begin n_fail++; $display("FAIL red_duty got %0d exp %0d", red, exp_red); end
        n_checks++;
        if (grn !== exp_grn) begin n_fail++; $display("FAIL green_duty got %0d exp %0d", grn, exp_grn); end
        n_checks++;
        if (blu !== 0) begin n_fail++; $display("FAIL blue_duty got %0d exp 0", blu); end
        n_checks++;
        if (on3 !== exp_on) begin n_fail++; $display("FAIL slot3_len got %0d exp %0d", on3, exp_on); end
    endtask

    task automatic test_frame_start_write();
        int guard = 0;
        while (frame_start !== 1'b1 && guard < FRAME + 2) begin
            tick();
            guard++;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_wait got no frame_start within %0d cycles", FRAME + 2);
        end
        wr_bus.wr_en = 1'b1; wr_bus.wr_idx = 3'd5; wr_bus.wr_data = 12'(($urandom & 32'hFFF) | 32'h888);
        tick();
        wr_bus.wr_idx = 3'd7; wr_bus.wr_data = 12'hFFF;
        tick();
        wr_bus.wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            n_checks++;
            if ({frame_start, en, color} !== {e_fs, e_en, e_col}) begin
                n_fail++;
                $display("FAIL fs_write n=%0d got fs/en/col=%b/%b/%b exp %b/%b/%b", n, frame_start, en, color, e_fs, e_en, e_col);
            end
        end
    endtask

    task automatic test_random_writes();
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            n_checks++;
            if ({frame_start, en, color} !== {e_fs, e_en, e_col}) begin
                n_fail++;
                $display("FAIL rand_wr n=%0d got fs/en/col=%b/%b/%b exp %b/%b/%b", n, frame_start, en, color, e_fs, e_en, e_col);
            end
            wr_bus.wr_en   = ($urandom_range(0, 19) == 0);
            wr_bus.wr_idx  = 3'($urandom_range(0, 7));
            wr_bus.wr_data = 12'($urandom);
            if (k == 10) begin
                wr_bus.wr_en = 1'b1; wr_bus.wr_idx = 3'd0; wr_bus.wr_data = 12'hF00;
            end
        end
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic test_buttons();
        int presses = 0;
        int phase_len [4] = '{DB + 12, DB + 12, 100, DB + 12};
        logic [NB-1:0] phase_pin [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
        logic [NB-1:0] phase_exp [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
        for (int p = 0; p < 4; p++) begin
            raw = phase_pin[p];
            for (int k = 0; k < phase_len[p]; k++) begin
                tick();
                n_checks++;
                if ({bst, bpr} !== {b_state_m, b_press_m}) begin
                    n_fail++;
                    $display("FAIL btn n=%0d got state/press=%b/%b exp %b/%b", n, bst, bpr, b_state_m, b_press_m);
                end
                if (bpr[0] === 1'b1) presses++;
            end
            n_checks++;
            if (bst !== phase_exp[p]) begin
                n_fail++;
                $display("FAIL btn_phase%0d got state %b exp %b", p, bst, phase_exp[p]);
            end
        end
        n_checks++;
        if (presses !== 1) begin n_fail++; $display("FAIL btn_press_count got %0d exp 1", presses); end
        for (int g = 0; g < 5; g++) begin
            int len = $urandom_range(1, DB - 5);
            for (int k = 0; k < len + int'($urandom_range(3, 20)); k++) begin
                raw = (k < len) ? 2'b01 : 2'b11;
                tick();
                n_checks++;
                if ({bst, bpr} !== {b_state_m, b_press_m}) begin
                    n_fail++;
                    $display("FAIL btn_glitch n=%0d got state/press=%b/%b exp %b/%b", n, bst, bpr, b_state_m, b_press_m);
                end
            end
        end
        n_checks++;
        if (bst !== 2'b00) begin n_fail++; $display("FAIL glitch_state got %b exp 00", bst); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        logic [NL-1:0] exp_en0;
`ifdef LED_SCAN_BLANK_EN
        exp_en0 = 7'b0000000;
`else
        exp_en0 = 7'b0000001;
`endif
        raw = 2'b00;
        while (!((n % FRAME) / SLOT_LEN == 4 && (n % SLOT_LEN) == 10) && guard < FRAME + 2) begin
            tick();
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({frame_start, en, color, bst, bpr} !== {1'b0, 7'b0, 3'b111, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset got fs/en/col/st/pr=%b/%b/%b/%b/%b exp 0/0000000/111/00/00", frame_start, en, color, bst, bpr);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({frame_start, en, color} !== {1'b1, exp_en0, 3'b111}) begin
            n_fail++;
            $display("FAIL restart got fs/en/col=%b/%b/%b exp 1/%b/111", frame_start, en, color, exp_en0);
        end
        for (int k = 0; k < FRAME + 20; k++) begin
            if (k == DB + 40) raw = 2'b11;
            tick();
            n_checks++;
            if ({frame_start, en, color, bst, bpr} !== {e_fs, e_en, e_col, b_state_m, b_press_m}) begin
                n_fail++;
                $display("FAIL post_reset n=%0d got fs/en/col/st/pr=%b/%b/%b/%b/%b exp %b/%b/%b/%b/%b",
                         n, frame_start, en, color, bst, bpr, e_fs, e_en, e_col, b_state_m, b_press_m);
            end
        end
    endtask

    initial begin
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_idx  = '0;
        wr_bus.wr_data = '0;
        test_reset();
        test_scan();
        test_write_mid_frame();
        test_frame_start_write();
        test_random_writes();
        test_buttons();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
